mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port instruction/data memory between the OpenMIPS fetch port and data port.
//   Sits in the SOPC between the openmips core and the memory.
//   Arbitrates requests, sequences wait-stated accesses and routes read data back to the winner.
//   Raises a pipeline stall request while either port is waiting.
// PARAMETERS
//   WAIT_STATES   1   extra cycles mem_ce_o is held per access (0..15)
//   STARVE_LIMIT  4   consecutive data grants with fetch pending before fetch is forced (0 = pure data priority)
// PORTS
//   clk          in   1   system clock, rising edge
//   rst          in   1   reset, asynchronous, active-low
//   if_req_i     in   1   fetch request; hold with if_addr_i until if_gnt_o
//   if_addr_i    in   32  fetch byte address
//   if_gnt_o     out  1   fetch request accepted this cycle
//   if_rvalid_o  out  1   one-cycle pulse; if_rdata_o valid
//   if_rdata_o   out  32  fetched instruction
//   d_req_i      in   1   data request; hold payload until d_gnt_o
//   d_we_i       in   1   1 = write, 0 = read
//   d_sel_i      in   4   byte enables
//   d_addr_i     in   32  data byte address
//   d_wdata_i    in   32  write data
//   d_gnt_o      out  1   data request accepted this cycle
//   d_rvalid_o   out  1   one-cycle pulse; read data valid, or write done
//   d_rdata_o    out  32  read data (0 for writes)
//   mem_ce_o     out  1   memory enable
//   mem_we_o     out  1   memory write enable
//   mem_sel_o    out  4   memory byte enables
//   mem_addr_o   out  32  memory address
//   mem_wdata_o  out  32  memory write data
//   mem_rdata_i  in   32  memory read data, combinational from mem_addr_o while mem_ce_o=1
//   stallreq_o   out  1   pipeline stall request
// BEHAVIOUR
//   Reset: state=IDLE, starve_cnt=0, all registered outputs 0. In-flight access dropped.
//   No rvalid is issued for an access dropped by reset.
//   FSM:
//     IDLE   -> ACCESS on any grant
//     ACCESS -> RESP when wait_cnt==WAIT_STATES
//     RESP   -> ACCESS on a grant, else IDLE
//   Grants are combinational, only in IDLE or RESP; at most one gnt per cycle.
//   Winner:
//     d wins if d_req_i, except when if_req_i && STARVE_LIMIT!=0 && starve_cnt==STARVE_LIMIT (then if wins).
//     Otherwise if wins when if_req_i.
//   starve_cnt:
//     +1 (saturating) on a d grant while if_req_i=1
//     cleared on an if grant, or on a d grant with if_req_i=0
//   Grant cycle latches owner, we, sel, addr and wdata (fetch: we=0, sel=4'hF, wdata=0).
//   ACCESS lasts WAIT_STATES+1 cycles; mem_* driven from latched regs and held stable; mem_ce_o=1.
//   Outside ACCESS: mem_ce_o=0, mem_we_o=0, all other mem_* outputs 0.
//   Last ACCESS cycle: mem_rdata_i registered into owner's rdata reg (0 if write).
//   RESP: owner's rvalid=1 for exactly one cycle. Non-owner rdata holds its previous value.
//   Latency, grant at cycle T: ACCESS T+1..T+1+WAIT_STATES, rvalid at T+2+WAIT_STATES.
//   Back-to-back accesses: one every WAIT_STATES+2 cycles.
//   stallreq_o = (if_req_i & ~if_gnt_o) | (d_req_i & ~d_gnt_o) | (state==ACCESS).
//   Simultaneous requests in RESP: arbitration uses current starve_cnt, before the RESP owner is cleared.
//   Requester dropping req before gnt is legal: no access occurs.
// STRUCTURE
//   Address/data widths and bus macros (`InstAddrBus, `InstBus, `DataBus) come from defines.v.
//   Add to defines.v: ARB_IDLE/ARB_ACCESS/ARB_RESP state encodings and ARB_OWNER_IF/ARB_OWNER_D.
//   Single module; no sub-module. wait_cnt and starve_cnt are inline counters.
// TESTING
//   1. if_req only, addr 0x4, WAIT_STATES=1:
//      gnt at T, mem_ce_o high T+1..T+2, if_rvalid_o at T+3 with rom word[1].
//   2. if_req and d_req (read 0x100) together:
//      d_gnt first, if_gnt in d's RESP cycle, stallreq_o high until if_rvalid_o.
//   3. d write, sel=4'b0011, wdata 0xDEADBEEF:
//      mem_we_o=1 and sel/wdata stable for the whole ACCESS; d_rvalid_o pulses with d_rdata_o=0.
//   4. d_req and if_req held continuously, STARVE_LIMIT=4:
//      grant order D,D,D,D,I repeating; STARVE_LIMIT=0 gives D only.
//   5. rst asserted low during ACCESS:
//      all outputs 0 immediately, no rvalid; after release, a fresh if_req completes normally.
//   6. WAIT_STATES=0, back-to-back fetches 0x0, 0x4, 0x8:
//      rvalid every 2 cycles, data in order.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and widths for the fetch/data memory port arbiter.
//   Contents: bus widths, arbiter state and owner encodings, the latched
//   access record, and the starvation counter update rule.
package mem_port_arbiter_pkg;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned SEL_W    = 4;
   localparam int unsigned WAIT_W   = 4;   // WAIT_STATES range 0..15
   localparam int unsigned STARVE_W = 8;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ACCESS,
      ARB_RESP
   } arb_state_e;

   typedef enum logic {
      ARB_OWNER_IF,
      ARB_OWNER_D
   } arb_owner_e;

   // Everything captured from the winning port in its grant cycle.
   typedef struct packed {
      arb_owner_e          owner;
      logic                we;
      logic [SEL_W-1:0]    sel;
      logic [ADDR_W-1:0]   addr;
      logic [DATA_W-1:0]   wdata;
   } arb_req_t;

   // Counts data grants taken while a fetch was left waiting; saturates.
   // Any grant that does not leave a fetch waiting clears it.
   function automatic logic [STARVE_W-1:0] starve_next(
      input logic [STARVE_W-1:0] cnt,
      input logic                if_req,
      input logic                if_gnt,
      input logic                d_gnt
   );
      if (d_gnt && if_req) begin
         return (cnt == '1) ? cnt : cnt + STARVE_W'(1);
      end
      if (if_gnt || d_gnt) begin
         return '0;
      end
      return cnt;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port instruction/data memory between the core's fetch
//   port and data port. Arbitrates, runs a wait-stated access, routes read
//   data back to the winner and requests a pipeline stall while a port waits.
// Ports
//   clk, rst (async, active-low)
//   Fetch:  if_req_i, if_addr_i -> if_gnt_o, if_rvalid_o, if_rdata_o
//   Data:   d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i
//           -> d_gnt_o, d_rvalid_o, d_rdata_o (0 for writes)
//   Memory: mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
//           mem_rdata_i (combinational from mem_addr_o)
//   stallreq_o: pipeline stall request
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned WAIT_STATES  = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [SEL_W-1:0]  d_sel_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              mem_ce_o,
   output logic              mem_we_o,
   output logic [SEL_W-1:0]  mem_sel_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stallreq_o
);

   arb_state_e          state;
   arb_owner_e          owner;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [STARVE_W-1:0] starve_cnt;

   logic     grant_ok;
   logic     force_if;
   logic     d_win;
   logic     if_win;
   arb_req_t next_req;

   // Grants are only issued while the memory is not busy. The data port wins
   // unless the fetch port has been passed over STARVE_LIMIT times in a row.
   always_comb begin
      grant_ok = (state != ARB_ACCESS);
      force_if = if_req_i && (STARVE_LIMIT != 0) &&
                 (starve_cnt == STARVE_W'(STARVE_LIMIT));
      d_win    = d_req_i && !force_if;
      if_win   = if_req_i && !d_win;
      if_gnt_o = grant_ok && if_win;
      d_gnt_o  = grant_ok && d_win;
      stallreq_o = (if_req_i && !if_gnt_o) || (d_req_i && !d_gnt_o) ||
                   (state == ARB_ACCESS);
   end

   // Payload of whichever port wins this cycle; a fetch is a full-word read.
   always_comb begin
      next_req = '0;
      if (d_win) begin
         next_req.owner = ARB_OWNER_D;
         next_req.we    = d_we_i;
         next_req.sel   = d_sel_i;
         next_req.addr  = d_addr_i;
         next_req.wdata = d_wdata_i;
      end else begin
         next_req.owner = ARB_OWNER_IF;
         next_req.we    = 1'b0;
         next_req.sel   = '1;
         next_req.addr  = if_addr_i;
         next_req.wdata = '0;
      end
   end

   // The mem_* output registers double as the latched access record: loaded
   // on the grant, held through ACCESS, and zeroed on entry to RESP after the
   // read data has been captured from them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ARB_IDLE;
         owner       <= ARB_OWNER_IF;
         wait_cnt    <= '0;
         starve_cnt  <= '0;
         mem_ce_o    <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_sel_o   <= '0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         if_rvalid_o <= 1'b0;
         if_rdata_o  <= '0;
         d_rvalid_o  <= 1'b0;
         d_rdata_o   <= '0;
      end else begin
         if_rvalid_o <= 1'b0;
         d_rvalid_o  <= 1'b0;
         starve_cnt  <= starve_next(starve_cnt, if_req_i, if_gnt_o, d_gnt_o);

         unique case (state)
            ARB_IDLE, ARB_RESP: begin
               if (if_gnt_o || d_gnt_o) begin
                  state       <= ARB_ACCESS;
                  wait_cnt    <= '0;
                  owner       <= next_req.owner;
                  mem_ce_o    <= 1'b1;
                  mem_we_o    <= next_req.we;
                  mem_sel_o   <= next_req.sel;
                  mem_addr_o  <= next_req.addr;
                  mem_wdata_o <= next_req.wdata;
               end else begin
                  state <= ARB_IDLE;
               end
            end

            ARB_ACCESS: begin
               if (wait_cnt == WAIT_W'(WAIT_STATES)) begin
                  state       <= ARB_RESP;
                  mem_ce_o    <= 1'b0;
                  mem_we_o    <= 1'b0;
                  mem_sel_o   <= '0;
                  mem_addr_o  <= '0;
                  mem_wdata_o <= '0;
                  if (owner == ARB_OWNER_D) begin
                     d_rvalid_o <= 1'b1;
                     d_rdata_o  <= mem_we_o ? '0 : mem_rdata_i;
                  end else begin
                     if_rvalid_o <= 1'b1;
                     if_rdata_o  <= mem_rdata_i;
                  end
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end

            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule
